// File: rtl/pit_irq_ctrl.sv
// pit_irq_ctrl
//   Collects one-cycle interrupt pulses from NUM_SRC interval-timer channels
//   into one level interrupt line. Each pulse is latched as pending. A
//   per-source enable mask gates eligibility. One eligible source at a time is
//   granted by round-robin and held until the consumer acknowledges it. A
//   source that fires again while still pending sets a sticky overrun flag.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   irq_in     per-source interrupt pulses
//   mask_wr    mask write strobe
//   mask_data  new enable mask (1 = enabled), loaded on mask_wr
//   ack        consumer acknowledge of the current grant
//   irq_out    level interrupt toward the consumer
//   irq_id     granted source index, valid while irq_out is high
//   pending    raw pending bits (before masking)
//   overrun    sticky per-source overrun flags
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no grant; arbitrate over pending & mask each cycle
// ASSERT | irq_out high, irq_id frozen; wait for ack
module pit_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_data,
  input  logic               ack,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun
);

  typedef enum logic {IDLE = 1'b0, ASSERT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, overrun_q, mask_q;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    idx_v;
  logic               found;

  assign elig = pending_q & mask_q;

  // Round-robin: first eligible source scanning upward from last+1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_v = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx_v = ID_W'((int'(last_q) + k) % NUM_SRC);
      if (!found && elig[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    last_d   = last_q;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = ASSERT;
          irq_id_d = pick;
          last_d   = pick;
        end
      end
      ASSERT: begin
        if (ack) begin
          state_d = IDLE;
          clr     = NUM_SRC'(1) << irq_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_id_q  <= '0;
      last_q    <= ID_W'(NUM_SRC - 1);
      pending_q <= '0;
      overrun_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      last_q    <= last_d;
      // A new pulse on the source being acked wins over the clear, so the
      // event is regranted; its overrun is still cleared by the ack.
      pending_q <= (pending_q & ~clr) | irq_in;
      overrun_q <= (overrun_q | (irq_in & pending_q)) & ~clr;
      if (mask_wr) mask_q <= mask_data;
    end
  end

  assign irq_out = (state_q == ASSERT);
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule
